// File: rtl/fft_frame_feeder_if.sv
// AXI4-stream links from the frame feeder to the FFT core:
// the one-beat direction config channel and the sample data channel.
interface fft_frame_feeder_if #(
  parameter int unsigned DATAIN_WIDTH = 16
);
  logic                      cfg_tvalid;
  logic                      cfg_tdata;
  logic                      data_tvalid;
  logic [2*DATAIN_WIDTH-1:0] data_tdata;
  logic                      data_tlast;
  logic                      data_tready;

  modport master (
    output cfg_tvalid, cfg_tdata,
    output data_tvalid, data_tdata, data_tlast,
    input  data_tready
  );

  modport slave (
    input  cfg_tvalid, cfg_tdata,
    input  data_tvalid, data_tdata, data_tlast,
    output data_tready
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Captures 2^LOG2_FFT_LEN ADC samples, converts them to signed left-aligned
// reals and streams them to the FFT core after a direction config beat.
module fft_frame_feeder #(
  parameter int unsigned LOG2_FFT_LEN = 8,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned DATAIN_WIDTH = 16
) (
  input  logic                    i_aclk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_fft_dir,
  input  logic                    i_sample_vld,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  fft_frame_feeder_if.master      axi4s,
  output logic                    o_busy,
  output logic                    o_frame_done
);
  localparam int unsigned N     = 1 << LOG2_FFT_LEN;
  localparam int unsigned SHIFT = INPUT_WIDTH - SAMPLE_WIDTH;

  typedef enum logic [2:0] {IDLE, CFG, CAPTURE, SEND, DONE} state_t;

  state_t state, state_nxt;

  logic                    dir_q;
  logic [LOG2_FFT_LEN-1:0] wr_cnt;
  logic [LOG2_FFT_LEN:0]   rd_cnt;
  logic [DATAIN_WIDTH-1:0] buffer [N];
  logic [DATAIN_WIDTH-1:0] rd_q;
  logic                    tvalid_q;
  logic                    tlast_q;

  logic wr_en;
  logic last_wr;
  logic fetch;
  logic accept;

  logic [SAMPLE_WIDTH-1:0]        s_twos;
  logic signed [INPUT_WIDTH-1:0]  s_aligned;
  logic signed [DATAIN_WIDTH-1:0] s_ext;

  always_comb begin
    s_twos    = {~i_sample[SAMPLE_WIDTH-1], i_sample[SAMPLE_WIDTH-2:0]};
    s_aligned = INPUT_WIDTH'(s_twos) << SHIFT;
    s_ext     = DATAIN_WIDTH'(s_aligned);
  end

  assign wr_en   = (state == CAPTURE) && i_sample_vld;
  assign last_wr = (wr_cnt == '1);
  assign accept  = tvalid_q && axi4s.data_tready;
  // The read register doubles as the output register: refill it whenever it
  // is empty or being consumed, so tvalid never depends on tready directly.
  assign fetch   = (state == SEND) && !rd_cnt[LOG2_FFT_LEN] && (!tvalid_q || axi4s.data_tready);

  always_ff @(posedge i_aclk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_start) state_nxt = CFG;
      CFG:     state_nxt = CAPTURE;
      CAPTURE: if (wr_en && last_wr) state_nxt = SEND;
      SEND:    if (accept && tlast_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy           = (state != IDLE);
    o_frame_done     = (state == DONE);
    axi4s.cfg_tvalid = (state == CFG);
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      dir_q    <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      rd_q     <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      if ((state == IDLE) && i_start) begin
        dir_q  <= i_fft_dir;
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (fetch) begin
        rd_q     <= buffer[rd_cnt[LOG2_FFT_LEN-1:0]];
        rd_cnt   <= rd_cnt + 1'b1;
        tvalid_q <= 1'b1;
        tlast_q  <= (rd_cnt[LOG2_FFT_LEN-1:0] == '1);
      end else if (accept) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (wr_en) buffer[wr_cnt] <= s_ext;
  end

  assign axi4s.cfg_tdata   = dir_q;
  assign axi4s.data_tvalid = tvalid_q;
  assign axi4s.data_tdata  = {{DATAIN_WIDTH{1'b0}}, rd_q};
  assign axi4s.data_tlast  = tlast_q;
endmodule
